// File: rtl/soc_tick_gen_if.sv
// APB slave bus bundle for the tick generator.
interface soc_tick_gen_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/soc_tick_gen.sv
// APB-programmable clock divider producing the machine-timer tick
// (one-cycle pulse or NRZ toggle), with a free-running count of ticks issued.
module soc_tick_gen #(
  parameter int unsigned       W_DIV     = 16,
  parameter logic [W_DIV-1:0]  DIV_RESET = W_DIV'(50),
  parameter bit                EN_RESET  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  soc_tick_gen_if.slave bus,
  output logic         tick
);

  localparam int unsigned DW = 32;

  localparam logic [15:0] ADDR_CTRL    = 16'h0000;
  localparam logic [15:0] ADDR_DIV     = 16'h0004;
  localparam logic [15:0] ADDR_COUNT   = 16'h0008;
  localparam logic [15:0] ADDR_TICKCNT = 16'h000C;

  localparam logic [W_DIV-1:0] COUNT_RESET =
    (DIV_RESET == '0) ? '0 : DIV_RESET - W_DIV'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             pready_q, pready_d;
  logic             en_q, en_d;
  logic             nrz_q, nrz_d;
  logic [W_DIV-1:0] div_q, div_d;
  logic [W_DIV-1:0] count_q, count_d;
  logic [DW-1:0]    tickcnt_q, tickcnt_d;
  logic             tick_q, tick_d;

  logic access_c;
  logic commit_c;
  logic clr_cnt_c;
  logic event_c;

  // Reload value D-1, with a zero divisor behaving as divide-by-one.
  function automatic logic [W_DIV-1:0] reload_val(input logic [W_DIV-1:0] d);
    return (d == '0) ? '0 : d - W_DIV'(1);
  endfunction

  assign access_c = bus.psel && bus.penable;
  // A write lands only on the IDLE->ACK edge, so a held access phase commits once.
  assign commit_c = (state_q == S_IDLE) && access_c && bus.pwrite;
  assign event_c  = en_q && (count_q == '0);

  // APB handshake: registered one-cycle pready per transfer.
  always_comb begin
    state_d  = state_q;
    pready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          state_d  = S_ACK;
          pready_d = 1'b1;
        end
      end
      S_ACK: begin
        if (!access_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register writes, divider down-counter, tick shaping and tick count.
  always_comb begin
    en_d      = en_q;
    nrz_d     = nrz_q;
    div_d     = div_q;
    clr_cnt_c = 1'b0;

    if (commit_c) begin
      case (bus.paddr)
        ADDR_CTRL: begin
          en_d  = bus.pwdata[0];
          nrz_d = bus.pwdata[1];
        end
        ADDR_DIV:     div_d     = bus.pwdata[W_DIV-1:0];
        ADDR_TICKCNT: clr_cnt_c = 1'b1;
        default: ;
      endcase
    end

    // Disabled: park at D-1 (tracks DIV writes). Just enabled: keep the parked value.
    if (!en_d) begin
      count_d = reload_val(div_d);
    end else if (!en_q) begin
      count_d = count_q;
    end else if (count_q == '0) begin
      count_d = reload_val(div_q);
    end else begin
      count_d = count_q - W_DIV'(1);
    end

    // Leaving NRZ mode forces a low; entering NRZ keeps the current level.
    if (!nrz_d) begin
      tick_d = nrz_q ? 1'b0 : event_c;
    end else begin
      tick_d = tick_q ^ event_c;
    end

    if (clr_cnt_c) begin
      tickcnt_d = '0;
    end else if (event_c) begin
      tickcnt_d = tickcnt_q + DW'(1);
    end else begin
      tickcnt_d = tickcnt_q;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pready_q  <= 1'b0;
      en_q      <= EN_RESET;
      nrz_q     <= 1'b0;
      div_q     <= DIV_RESET;
      count_q   <= COUNT_RESET;
      tickcnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      en_q      <= en_d;
      nrz_q     <= nrz_d;
      div_q     <= div_d;
      count_q   <= count_d;
      tickcnt_q <= tickcnt_d;
      tick_q    <= tick_d;
    end
  end

  // Read mux, combinational from paddr; unmapped offsets read zero.
  always_comb begin
    bus.prdata = '0;
    case (bus.paddr)
      ADDR_CTRL:    bus.prdata = {30'd0, nrz_q, en_q};
      ADDR_DIV:     bus.prdata = DW'(div_q);
      ADDR_COUNT:   bus.prdata = DW'(count_q);
      ADDR_TICKCNT: bus.prdata = tickcnt_q;
      default: ;
    endcase
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = 1'b0;
  assign tick        = tick_q;

  // Write-data bits above the divider width have no destination.
  logic unused_pwdata_hi;
  assign unused_pwdata_hi = ^bus.pwdata[DW-1:W_DIV];

endmodule

// File: tb/tb_soc_tick_gen.sv
// Directed bench for soc_tick_gen: reset values, pulse/NRZ timing, enable
// control, APB hold behaviour, register map edges, TICKCNT wrap/clear, reset mid-transfer.
module tb_soc_tick_gen;

  logic clk;
  logic rst_n;
  logic tick;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd;

  soc_tick_gen_if bus ();

  soc_tick_gen #(
    .W_DIV     (16),
    .DIV_RESET (16'd50),
    .EN_RESET  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Combinational read-back through the prdata mux.
  task automatic peek(input logic [15:0] a, output logic [31:0] d);
    bus.paddr = a;
    #1;
    d = bus.prdata;
  endtask

  task automatic peek_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] v;
    peek(a, v);
    chk(tag, v, exp);
  endtask

  // Called just after a negedge; returns at the negedge following the commit edge.
  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    bus.paddr   = a;
    bus.pwdata  = d;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pready_setup", 32'(bus.pready), 32'd0);
    bus.penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pready_ack", 32'(bus.pready), 32'd1);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.paddr   = '0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pready", 32'(bus.pready), 32'd0);
    chk("rst_pslverr", 32'(bus.pslverr), 32'd0);
    peek_chk("rst_ctrl", 16'h0000, 32'h1);
    peek_chk("rst_div", 16'h0004, 32'd50);
    peek_chk("rst_count", 16'h0008, 32'd49);
    peek_chk("rst_tickcnt", 16'h000C, 32'd0);

    // 1: default divide-by-50 pulses after release
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 151; k++) begin
      @(negedge clk);
      chk("t1_tick", 32'(tick), 32'(k % 50 == 0));
    end
    peek_chk("t1_tickcnt", 16'h000C, 32'd3);
    peek_chk("t1_count", 16'h0008, 32'd48);

    // 2: divide by 3, then DIV=0 gives a tick every cycle
    apb_write(16'h0000, 32'h0);
    apb_write(16'h0004, 32'd3);
    peek_chk("t2_count_dis", 16'h0008, 32'd2);
    apb_write(16'h0000, 32'h1);
    peek_chk("t2_count_en", 16'h0008, 32'd2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t2_tick_div3", 32'(tick), 32'(k % 3 == 0));
    end
    apb_write(16'h0004, 32'd0);
    chk("t2_tick_pre", 32'(tick), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_tick_div0", 32'(tick), 32'd1);
    end
    peek_chk("t2_tickcnt_a", 16'h000C, 32'd11);
    @(negedge clk);
    peek_chk("t2_tickcnt_b", 16'h000C, 32'd12);

    // 3: NRZ with DIV=4, then back to pulse mode
    apb_write(16'h0000, 32'h0);
    chk("t3_tick_dis", 32'(tick), 32'd1);
    peek_chk("t3_tickcnt", 16'h000C, 32'd14);
    apb_write(16'h0004, 32'd4);
    apb_write(16'h0000, 32'h3);
    chk("t3_tick_nrz0", 32'(tick), 32'd0);
    peek_chk("t3_ctrl", 16'h0000, 32'h3);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("t3_tick_nrz", 32'(tick), 32'((k / 4) % 2));
    end
    apb_write(16'h0000, 32'h1);
    chk("t3_tick_force0", 32'(tick), 32'd0);
    for (int k = 16; k <= 24; k++) begin
      @(negedge clk);
      chk("t3_tick_pulse", 32'(tick), 32'(k % 4 == 0));
    end

    // 4: disable mid-count, hold, re-enable
    apb_write(16'h0000, 32'h0);
    chk("t4_tick_dis", 32'(tick), 32'd0);
    peek_chk("t4_count_dis", 16'h0008, 32'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t4_tick_hold", 32'(tick), 32'd0);
    end
    peek_chk("t4_count_hold", 16'h0008, 32'd3);
    apb_write(16'h0000, 32'h1);
    peek_chk("t4_count_en", 16'h0008, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t4_tick_reen", 32'(tick), 32'(k % 4 == 0));
    end

    // 5: held access phase commits once; register map edges
    bus.paddr   = 16'h0004;
    bus.pwdata  = 32'd7;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.penable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t5_pready_hold", 32'(bus.pready), 32'(i == 1));
      if (i == 3) bus.pwdata = 32'd9;
    end
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    @(negedge clk);
    chk("t5_pready_end", 32'(bus.pready), 32'd0);
    peek_chk("t5_div_once", 16'h0004, 32'd7);
    peek_chk("t5_unmapped_rd", 16'h0010, 32'd0);
    apb_write(16'h0010, 32'hFFFF_FFFF);
    peek_chk("t5_unmapped_div", 16'h0004, 32'd7);
    peek_chk("t5_unmapped_ctrl", 16'h0000, 32'h1);
    apb_write(16'h0000, 32'h0);
    peek_chk("t5_count_dis", 16'h0008, 32'd6);
    apb_write(16'h0008, 32'h1234);
    peek_chk("t5_count_ro", 16'h0008, 32'd6);
    apb_write(16'h0000, 32'hFFFF_FFFC);
    peek_chk("t5_ctrl_hi", 16'h0000, 32'h0);
    apb_write(16'h0004, 32'hABCD_0005);
    peek_chk("t5_div_hi", 16'h0004, 32'h5);
    peek_chk("t5_count_track", 16'h0008, 32'h4);

    // 6: TICKCNT wrap, clear vs event, reset mid-transfer
    apb_write(16'h0004, 32'd0);
    peek_chk("t6_count_div0", 16'h0008, 32'd0);
    apb_write(16'h0000, 32'h1);
    @(negedge clk);
    chk("t6_tick_every", 32'(tick), 32'd1);
    force dut.tickcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.tickcnt_q;
    peek_chk("t6_tickcnt_max", 16'h000C, 32'hFFFF_FFFF);
    @(negedge clk);
    peek_chk("t6_tickcnt_wrap", 16'h000C, 32'd0);
    @(negedge clk);
    peek_chk("t6_tickcnt_after", 16'h000C, 32'd1);
    apb_write(16'h000C, 32'hDEAD_BEEF);
    peek_chk("t6_clear_wins", 16'h000C, 32'd0);
    @(negedge clk);
    peek_chk("t6_clear_next", 16'h000C, 32'd1);

    bus.paddr   = 16'h0000;
    bus.pwdata  = 32'h3;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_tick_pre_rst", 32'(tick), 32'd1);
    bus.penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tick", 32'(tick), 32'd0);
    chk("t6_rst_pready", 32'(bus.pready), 32'd0);
    peek_chk("t6_rst_ctrl", 16'h0000, 32'h1);
    peek_chk("t6_rst_div", 16'h0004, 32'd50);
    peek_chk("t6_rst_count", 16'h0008, 32'd49);
    peek_chk("t6_rst_tickcnt", 16'h000C, 32'd0);
    bus.paddr = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_hold_pready", 32'(bus.pready), 32'd0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    rst_n = 1'b1;
    peek_chk("t6_dropped_write", 16'h0000, 32'h1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chk("t6_tick_restart", 32'(tick), 32'(k == 50));
    end
    apb_write(16'h0004, 32'd12);
    peek_chk("t6_write_after_rst", 16'h0004, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
